// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with branch resolution
//
// Purpose: issues byte/half/word/double loads and stores to a variable-latency
// data memory via a req/ack handshake, stalls the pipeline while waiting,
// aborts with a bus error after TIMEOUT cycles, rejects misaligned or illegal
// accesses, sign/zero extends load data and resolves branch conditions.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_valid                 instruction in MEM is valid
//   i_memRead, i_memWrite   load / store
//   i_funct3                access size+sign (mem) or condition (branch)
//   i_memAddr, i_wrData     byte address, LSB-aligned store data
//   i_branch, i_jump        conditional branch / unconditional jump
//   i_zero, i_lt, i_ltu     ALU flags
//   o_PCSrc                 take branch/jump target (combinational)
//   o_stall                 freeze upstream pipeline (combinational)
//   o_done, o_readData      access-complete pulse, extended load data
//   o_misaligned, o_busErr  rejected-access pulse, timeout pulse
//   dmem_*                  data-memory request side
module mem_lsu #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic                i_memRead,
   input  logic                i_memWrite,
   input  logic [2:0]          i_funct3,
   input  logic [ADDR_W-1:0]   i_memAddr,
   input  logic [XLEN-1:0]     i_wrData,
   input  logic                i_branch,
   input  logic                i_jump,
   input  logic                i_zero,
   input  logic                i_lt,
   input  logic                i_ltu,
   output logic                o_PCSrc,
   output logic                o_stall,
   output logic                o_done,
   output logic [XLEN-1:0]     o_readData,
   output logic                o_misaligned,
   output logic                o_busErr,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [XLEN-1:0]     dmem_wdata,
   output logic [XLEN/8-1:0]   dmem_be,
   input  logic                dmem_ack,
   input  logic [XLEN-1:0]     dmem_rdata
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              ld_active;
   logic              ld_uns;
   logic [1:0]        ld_size;
   logic [OFF_W-1:0]  ld_off;

   // ---------------- branch resolution ----------------
   logic cond;
   always_comb begin
      cond = 1'b0;
      case (i_funct3)
         3'b000:  cond = i_zero;
         3'b001:  cond = ~i_zero;
         3'b100:  cond = i_lt;
         3'b101:  cond = ~i_lt;
         3'b110:  cond = i_ltu;
         3'b111:  cond = ~i_ltu;
         default: cond = 1'b0;
      endcase
   end

   assign o_PCSrc = i_valid & (i_jump | (i_branch & cond));

   // ---------------- access decode ----------------
   logic [1:0]        size;
   logic [OFF_W-1:0]  off;
   logic              legal;
   logic              misal;
   logic              start;
   logic [NB-1:0]     be_next;
   logic [XLEN-1:0]   wdata_next;
   int                nbytes;

   assign size  = i_funct3[1:0];
   assign off   = i_memAddr[OFF_W-1:0];
   assign start = (state == IDLE) & i_valid & (i_memRead | i_memWrite);

   always_comb begin
      logic size_ok;
      nbytes  = 1 << size;
      size_ok = (size != 2'b11) || (XLEN == 64);
      legal   = size_ok;
      // Unsigned loads exist for sizes narrower than XLEN only.
      if (i_memRead && i_funct3[2])
         legal = (size == 2'b00) || (size == 2'b01) || ((size == 2'b10) && (XLEN == 64));
      misal   = !legal || ((int'(off) & (nbytes - 1)) != 0);
      be_next = NB'((1 << nbytes) - 1) << off;
      // Replicate the low access-size bytes of the store data into every lane.
      wdata_next = '0;
      for (int i = 0; i < NB; i++)
         wdata_next[8*i +: 8] = i_wrData[8*(i & (nbytes - 1)) +: 8];
   end

   assign o_stall = (state == REQ) | (start & ~misal);

   // ---------------- load data extraction ----------------
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_res;
   logic            sign;
   int              nbits;

   always_comb begin
      shifted = dmem_rdata >> {ld_off, 3'b000};
      nbits   = 8 << ld_size;
      if (nbits > XLEN)
         nbits = XLEN;
      sign    = ~ld_uns & shifted[nbits-1];
      load_res = '0;
      for (int b = 0; b < XLEN; b++)
         load_res[b] = (b < nbits) ? shifted[b] : sign;
   end

   logic timeout;
   assign timeout = (TIMEOUT != 0) && (cnt == CNT_MAX);

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= IDLE;
         cnt          <= '0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_be      <= '0;
         o_readData   <= '0;
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         o_busErr     <= 1'b0;
         ld_active    <= 1'b0;
         ld_uns       <= 1'b0;
         ld_size      <= 2'b00;
         ld_off       <= '0;
      end else begin
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         o_busErr     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (misal) begin
                     o_misaligned <= 1'b1;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= i_memWrite;
                     dmem_addr  <= {i_memAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     dmem_be    <= be_next;
                     dmem_wdata <= wdata_next;
                     ld_active  <= i_memRead;
                     ld_uns     <= i_funct3[2];
                     ld_size    <= size;
                     ld_off     <= off;
                     cnt        <= '0;
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  if (ld_active)
                     o_readData <= load_res;
                  o_done <= 1'b1;
                  cnt    <= '0;
                  state  <= RESP;
               end else if (timeout) begin
                  dmem_req <= 1'b0;
                  if (ld_active)
                     o_readData <= '0;
                  o_done   <= 1'b1;
                  o_busErr <= 1'b1;
                  cnt      <= '0;
                  state    <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               // The completed instruction is still presented here; do not restart it.
               dmem_req <= 1'b0;
               cnt      <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed table-driven bench for mem_lsu
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid, mem_read, mem_write, branch, jump, zero, lt, ltu;
   logic [2:0]  funct3;
   logic [31:0] mem_addr, wr_data;
   logic        pc_src, stall, done, misaligned, bus_err;
   logic [31:0] read_data;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
      .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_memRead(mem_read),
      .i_memWrite(mem_write), .i_funct3(funct3), .i_memAddr(mem_addr),
      .i_wrData(wr_data), .i_branch(branch), .i_jump(jump), .i_zero(zero),
      .i_lt(lt), .i_ltu(ltu), .o_PCSrc(pc_src), .o_stall(stall), .o_done(done),
      .o_readData(read_data), .o_misaligned(misaligned), .o_busErr(bus_err),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        valid, branch, jump;
      logic [2:0]  f3;
      logic        zero, lt, ltu;
      logic        exp;
   } br_t;

   typedef struct {
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdata;
      int          ack_dly;
      logic        mis;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_read;
   } acc_t;

   task automatic run_acc(input acc_t v, input string nm);
      int stalls, reqc;
      bit seen;
      @(negedge clk);
      valid = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
      mem_addr = v.addr; wr_data = v.wd;
      #1;
      chk({nm, "_stall0"}, 32'(stall), 32'(!v.mis));
      if (v.mis) begin
         @(posedge clk); @(negedge clk);
         valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         chk({nm, "_mis"}, 32'(misaligned), 32'd1);
         chk({nm, "_noreq"}, 32'(dmem_req), 32'd0);
         chk({nm, "_nodone"}, 32'(done), 32'd0);
         @(posedge clk); @(negedge clk);
         chk({nm, "_mis_pulse"}, 32'(misaligned), 32'd0);
         return;
      end
      stalls = 1; reqc = 0; seen = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(posedge clk); @(negedge clk);
         dmem_ack = 1'b0;
         if (done) begin
            seen = 1;
         end else begin
            if (stall) stalls++;
            if (dmem_req) begin
               reqc++;
               if (reqc == 1) begin
                  chk({nm, "_addr"}, dmem_addr, v.e_addr);
                  chk({nm, "_be"}, 32'(dmem_be), 32'(v.e_be));
                  chk({nm, "_wdata"}, dmem_wdata, v.e_wd);
                  chk({nm, "_we"}, 32'(dmem_we), 32'(v.wr));
               end
               if (reqc == v.ack_dly) begin
                  dmem_ack = 1'b1;
                  dmem_rdata = v.rdata;
               end
            end
         end
      end
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      chk({nm, "_stalls"}, 32'(stalls), 32'(v.ack_dly + 1));
      chk({nm, "_rdata"}, read_data, v.e_read);
      chk({nm, "_buserr"}, 32'(bus_err), 32'd0);
      chk({nm, "_stall_resp"}, 32'(stall), 32'd0);
      // Instruction still presented during RESP: it must not restart.
      @(posedge clk); @(negedge clk);
      valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      chk({nm, "_no_restart"}, 32'(dmem_req), 32'd0);
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   br_t  bv[11];
   acc_t av[14];

   initial begin
      int reqc;
      bit seen;

      bv[0]  = '{1, 1, 0, 3'b101, 0, 0, 0, 1};
      bv[1]  = '{1, 1, 0, 3'b000, 0, 0, 0, 0};
      bv[2]  = '{0, 0, 1, 3'b000, 0, 0, 0, 0};
      bv[3]  = '{1, 0, 1, 3'b000, 0, 0, 0, 1};
      bv[4]  = '{1, 1, 0, 3'b000, 1, 0, 0, 1};
      bv[5]  = '{1, 1, 0, 3'b001, 1, 0, 0, 0};
      bv[6]  = '{1, 1, 0, 3'b100, 0, 1, 0, 1};
      bv[7]  = '{1, 1, 0, 3'b110, 0, 1, 0, 0};
      bv[8]  = '{1, 1, 0, 3'b111, 0, 0, 0, 1};
      bv[9]  = '{1, 1, 0, 3'b010, 1, 1, 1, 0};
      bv[10] = '{1, 1, 0, 3'b101, 0, 1, 0, 0};

      //          rd wr f3      addr          wd            rdata         dly mis e_addr        e_be     e_wd          e_read
      av[0]  = '{1, 0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEADBEEF, 2, 0, 32'h0000_0104, 4'b1111, 32'h0,        32'hDEADBEEF};
      av[1]  = '{1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF0000, 1, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFFFF80};
      av[2]  = '{1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF0000, 1, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'h00000080};
      av[3]  = '{0, 1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 32'h0,        1, 0, 32'h0000_0200, 4'b1100, 32'hABCDABCD, 32'h00000080};
      av[4]  = '{1, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h80017FFF, 1, 0, 32'h0000_0100, 4'b1100, 32'h0,        32'hFFFF8001};
      av[5]  = '{1, 0, 3'b101, 32'h0000_0106, 32'h0,        32'h80017FFF, 1, 0, 32'h0000_0104, 4'b1100, 32'h0,        32'h00008001};
      av[6]  = '{0, 1, 3'b000, 32'h0000_0305, 32'h000000A5, 32'h0,        3, 0, 32'h0000_0304, 4'b0010, 32'hA5A5A5A5, 32'h00008001};
      av[7]  = '{1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0,        32'h0};
      av[8]  = '{1, 0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0,        32'h0};
      av[9]  = '{1, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0,        32'h0};
      av[10] = '{1, 0, 3'b000, 32'h0000_0100, 32'h0,        32'h1234567F, 1, 0, 32'h0000_0100, 4'b0001, 32'h0,        32'h0000007F};
      av[11] = '{0, 1, 3'b010, 32'h0000_0400, 32'hCAFEF00D, 32'h0,        2, 0, 32'h0000_0400, 4'b1111, 32'hCAFEF00D, 32'h0000007F};
      av[12] = '{1, 0, 3'b111, 32'h0000_0100, 32'h0,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0,        32'h0};
      av[13] = '{1, 0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,        1, 1, 32'h0,         4'b0000, 32'h0,        32'h0};

      reset = 1'b1; valid = 0; mem_read = 0; mem_write = 0; branch = 0; jump = 0;
      zero = 0; lt = 0; ltu = 0; funct3 = 3'b000; mem_addr = '0; wr_data = '0;
      dmem_ack = 0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_be", 32'(dmem_be), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_flags", {29'd0, done, misaligned, bus_err}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         valid = bv[i].valid; branch = bv[i].branch; jump = bv[i].jump;
         funct3 = bv[i].f3; zero = bv[i].zero; lt = bv[i].lt; ltu = bv[i].ltu;
         #1;
         chk($sformatf("br%0d_pcsrc", i), 32'(pc_src), 32'(bv[i].exp));
         chk($sformatf("br%0d_stall", i), 32'(stall), 32'd0);
      end
      @(negedge clk);
      valid = 0; branch = 0; jump = 0; zero = 0; lt = 0; ltu = 0;

      for (int i = 0; i < 14; i++)
         run_acc(av[i], $sformatf("acc%0d", i));

      // Timeout: LW with no ack; req must stay up for exactly 4 cycles.
      @(negedge clk);
      valid = 1; mem_read = 1; funct3 = 3'b010; mem_addr = 32'h0000_0108;
      reqc = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk); @(negedge clk);
         if (done) seen = 1;
         else if (dmem_req) reqc++;
      end
      chk("to_done", 32'(seen), 32'd1);
      chk("to_req_cycles", 32'(reqc), 32'd4);
      chk("to_buserr", 32'(bus_err), 32'd1);
      chk("to_req_low", 32'(dmem_req), 32'd0);
      chk("to_rdata", read_data, 32'd0);
      @(posedge clk); @(negedge clk);
      valid = 0; mem_read = 0;
      chk("to_buserr_pulse", 32'(bus_err), 32'd0);

      // Ack outside REQ is ignored.
      dmem_ack = 1; dmem_rdata = 32'h5555_5555;
      @(posedge clk); @(negedge clk);
      dmem_ack = 0;
      @(posedge clk); @(negedge clk);
      chk("stray_ack_done", 32'(done), 32'd0);
      chk("stray_ack_rdata", read_data, 32'd0);

      // Reset in the middle of a request.
      @(negedge clk);
      valid = 1; mem_read = 1; funct3 = 3'b010; mem_addr = 32'h0000_0110;
      @(posedge clk); @(negedge clk);
      chk("mid_req_up", 32'(dmem_req), 32'd1);
      reset = 1;
      @(posedge clk); @(negedge clk);
      reset = 0; valid = 0; mem_read = 0;
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("mid_rst_idle_stall", 32'(stall), 32'd0);
      chk("mid_rst_no_done", 32'(done), 32'd0);
      // A fresh access after reset runs with normal IDLE latency.
      run_acc(av[10], "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
